// File: rtl/tl_sys_tgt_pkg.sv
// rtl/tl_sys_tgt_pkg.sv - shared types and constants for the TileLink system register target
package tl_sys_tgt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [63:0] ERR_RDATA = 64'hDEAD_DEAD_DEAD_DEAD;

    // Index must also reach the two optional counter slots above the register file.
    function automatic int idx_width(input int num_regs);
        return $clog2(num_regs + 2);
    endfunction

endpackage

// File: rtl/tl_sys_tgt_decode.sv
// rtl/tl_sys_tgt_decode.sv - combinational address decode; TL_SYS_TGT_PERF_EN adds the counter slots
module tl_sys_tgt_decode
    import tl_sys_tgt_pkg::*;
#(
    parameter int                   ADR_WIDTH = 32,
    parameter logic [ADR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                   NUM_REGS  = 16,
    parameter int                   IW        = idx_width(NUM_REGS)
) (
    input  logic [ADR_WIDTH-1:0] adr,
    output logic                 in_range,
    output logic [IW-1:0]        index,
    output logic                 is_counter
);

    localparam logic [ADR_WIDTH-1:0] NREG = ADR_WIDTH'(NUM_REGS);

    logic [ADR_WIDTH-1:0] offset;
    logic [ADR_WIDTH-1:0] word;
    logic                 aligned;
    logic                 in_regs;

    // Unsigned subtraction: addresses below the base wrap to huge offsets and fall out of range.
    assign offset  = adr - BASE_ADDR;
    assign word    = offset >> 3;
    assign aligned = (offset[2:0] == 3'b000);
    assign in_regs = aligned && (word < NREG);

`ifdef TL_SYS_TGT_PERF_EN
    assign is_counter = aligned && ((word == NREG) || (word == NREG + ADR_WIDTH'(1)));
`else
    assign is_counter = 1'b0;
`endif

    assign in_range = in_regs || is_counter;
    assign index    = word[IW-1:0];

endmodule

// File: rtl/tl_sys_reg_target.sv
// rtl/tl_sys_reg_target.sv - req/ack register target with programmable latency; TL_SYS_TGT_PERF_EN adds access counters
module tl_sys_reg_target
    import tl_sys_tgt_pkg::*;
#(
    parameter int                   ADR_WIDTH = 32,
    parameter logic [ADR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                   NUM_REGS  = 16,
    parameter int                   LATENCY   = 2,
    parameter logic [63:0]          RST_VAL   = 64'h0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic                 rdWr,
    input  logic [63:0]          wrDat,
    output logic [63:0]          rdDat,
    output logic                 ack,
    output logic                 err
);

    localparam int IW = idx_width(NUM_REGS);

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [ADR_WIDTH-1:0] cap_adr;
    logic                 cap_rd;
    logic [63:0]          cap_dat;
    logic [63:0]          regs [NUM_REGS];
    logic [63:0]          rd_hold;
    logic [63:0]          rd_val;
    logic                 in_range;
    logic [IW-1:0]        index;
    logic                 is_counter;
    logic                 acc_ok;

    tl_sys_tgt_decode #(
        .ADR_WIDTH (ADR_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IW        (IW)
    ) u_decode (
        .adr        (cap_adr),
        .in_range   (in_range),
        .index      (index),
        .is_counter (is_counter)
    );

    // Counters are read-only: a write that lands on one is treated as an error.
    assign acc_ok = in_range && !(is_counter && !cap_rd);
    assign ack    = (state == ACK);
    assign err    = ack && !acc_ok;
    assign rdDat  = (ack && cap_rd) ? rd_val : rd_hold;

`ifdef TL_SYS_TGT_PERF_EN
    logic [63:0] rd_cnt, wr_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (ack && acc_ok) begin
            if (cap_rd) rd_cnt <= rd_cnt + 64'd1;
            else        wr_cnt <= wr_cnt + 64'd1;
        end
    end
`endif

    always_comb begin
        rd_val = ERR_RDATA;
        if (in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (index == IW'(i)) rd_val = regs[i];
            end
`ifdef TL_SYS_TGT_PERF_EN
            // The read-count value returned already includes the read that fetches it.
            if (index == IW'(NUM_REGS))     rd_val = rd_cnt + 64'd1;
            if (index == IW'(NUM_REGS + 1)) rd_val = wr_cnt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = ACK;
            end
            ACK:     state_nxt = DRAIN;
            DRAIN:   if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cap_adr <= '0;
            cap_rd  <= 1'b0;
            cap_dat <= '0;
            rd_hold <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                cap_adr <= adr;
                cap_rd  <= rdWr;
                cap_dat <= wrDat;
            end
            if (ack && cap_rd) rd_hold <= rd_val;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ack && !cap_rd && acc_ok && index == IW'(i)) regs[i] <= cap_dat;
            end
        end
    end

endmodule

// File: tb/tb_tl_sys_reg_target.sv
// tb/tb_tl_sys_reg_target.sv - scoreboard bench for tl_sys_reg_target at LATENCY 2 and LATENCY 1
module tb_tl_sys_reg_target;

    localparam logic [63:0] RV   = 64'hA5A5_0000_0000_5A5A;
    localparam logic [63:0] DEAD = 64'hDEAD_DEAD_DEAD_DEAD;

    logic        clock = 1'b0;
    logic        reset;
    logic        req   [2];
    logic [31:0] adr   [2];
    logic        rdWr  [2];
    logic [63:0] wrDat [2];
    logic [63:0] rdDat [2];
    logic        ack   [2];
    logic        err   [2];

    typedef struct {
        logic        rd;
        logic        err;
        logic [63:0] rdat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [2][16];
    int          lat   [2] = '{2, 1};
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    tl_sys_reg_target #(.ADR_WIDTH(32), .BASE_ADDR(32'h1000), .NUM_REGS(16), .LATENCY(2), .RST_VAL(RV)) u_dut0 (
        .clock(clock), .reset(reset), .req(req[0]), .adr(adr[0]), .rdWr(rdWr[0]),
        .wrDat(wrDat[0]), .rdDat(rdDat[0]), .ack(ack[0]), .err(err[0]));

    tl_sys_reg_target #(.ADR_WIDTH(32), .BASE_ADDR(32'h1000), .NUM_REGS(16), .LATENCY(1), .RST_VAL(RV)) u_dut1 (
        .clock(clock), .reset(reset), .req(req[1]), .adr(adr[1]), .rdWr(rdWr[1]),
        .wrDat(wrDat[1]), .rdDat(rdDat[1]), .ack(ack[1]), .err(err[1]));

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h1080) && (a[2:0] == 3'b000);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'h1000) >> 3;
        return int'(off[3:0]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model[d][i] = RV;
    endtask

    // mode 0: drop req after ack; 1: hold req 10 cycles; 2: drop req right after capture
    task automatic xact(input int d, input bit rd, input logic [31:0] a, input logic [63:0] wd,
                        input int mode = 0, input bit ovr = 0, input logic [63:0] ovr_val = '0);
        exp_t e, got;
        int   cyc, extra, n;
        e.rd   = rd;
        e.err  = ovr ? 1'b0 : !in_rng(a);
        e.rdat = ovr ? ovr_val : (in_rng(a) ? model[d][idx_of(a)] : DEAD);
        if (!rd && in_rng(a) && !ovr) model[d][idx_of(a)] = wd;
        sb.push_back(e);
        @(negedge clock);
        req[d] = 1'b1; adr[d] = a; rdWr[d] = rd; wrDat[d] = wd;
        @(posedge clock); #1;
        adr[d] = a ^ 32'h8; wrDat[d] = ~wd; rdWr[d] = !rd;
        if (mode == 2) req[d] = 1'b0;
        cyc = 1;
        while (!ack[d] && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        got = sb.pop_front();
        checks++;
        if (!ack[d]) begin
            errors++;
            $display("FAIL ack_timeout dut%0d adr %h: no ack in %0d cycles", d, a, cyc);
        end else begin
            if (cyc != lat[d]) begin
                errors++;
                $display("FAIL ack_latency dut%0d adr %h: got %0d want %0d", d, a, cyc, lat[d]);
            end
            checks++;
            if (err[d] !== got.err) begin
                errors++;
                $display("FAIL err dut%0d adr %h: got %b want %b", d, a, err[d], got.err);
            end
            if (got.rd) begin
                checks++;
                if (rdDat[d] !== got.rdat) begin
                    errors++;
                    $display("FAIL rdDat dut%0d adr %h: got %h want %h", d, a, rdDat[d], got.rdat);
                end
            end
        end
        if (mode != 1) req[d] = 1'b0;
        n = (mode == 1) ? 9 : 3;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (ack[d]) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL extra_ack dut%0d adr %h: got %0d extra pulses want 0", d, a, extra);
        end
        req[d] = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; adr[d] = '0; rdWr[d] = 1'b0; wrDat[d] = '0;
        end
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdDat[d] !== 64'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got ack %b err %b rdDat %h want 0 0 0",
                         d, ack[d], err[d], rdDat[d]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_write_read();
        xact(0, 1'b0, 32'h1008, 64'h1122_3344_5566_7788);
        xact(0, 1'b1, 32'h1008, '0);
        xact(0, 1'b1, 32'h1000, '0);
        xact(0, 1'b0, 32'h1078, 64'hFEDC_BA98_7654_3210);
        xact(0, 1'b1, 32'h1078, '0);
    endtask

    task automatic test_out_of_range();
`ifdef TL_SYS_TGT_PERF_EN
        xact(0, 1'b1, 32'h1090, '0);
`else
        xact(0, 1'b1, 32'h1080, '0);
`endif
        xact(0, 1'b0, 32'h0FF8, 64'h0BAD_0BAD_0BAD_0BAD);
        xact(0, 1'b0, 32'h1014, 64'h0BAD_0BAD_0BAD_0BAD);
        xact(0, 1'b1, 32'h100C, '0);
        for (int i = 0; i < 16; i++) xact(0, 1'b1, 32'h1000 + 32'(i * 8), '0);
    endtask

    task automatic test_hold_req();
        xact(0, 1'b0, 32'h1010, 64'h0123_4567_89AB_CDEF, 1);
        xact(0, 1'b1, 32'h1010, '0);
        xact(0, 1'b1, 32'h1008, '0, 2);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req[0] = 1'b1; adr[0] = 32'h1000; rdWr[0] = 1'b0; wrDat[0] = 64'h5555_6666_7777_8888;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ack[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got ack %b err %b want 0 0", ack[0], err[0]);
        end
        @(posedge clock); #1;
        checks++;
        if (ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ack: got %b want 0", ack[0]);
        end
        req[0] = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        xact(0, 1'b1, 32'h1000, '0);
        xact(0, 1'b1, 32'h1008, '0);
    endtask

    task automatic test_back_to_back();
        xact(1, 1'b1, 32'h1000, '0);
        xact(1, 1'b0, 32'h1020, 64'hCAFE_F00D_1234_5678);
        xact(1, 1'b1, 32'h1020, '0);
        xact(1, 1'b1, 32'h1080, '0);
        xact(1, 1'b1, 32'h1020, '0);
    endtask

`ifdef TL_SYS_TGT_PERF_EN
    task automatic test_perf();
        test_reset();
        xact(0, 1'b0, 32'h1000, 64'h1);
        xact(0, 1'b0, 32'h1008, 64'h2);
        xact(0, 1'b0, 32'h1010, 64'h3);
        xact(0, 1'b1, 32'h1000, '0);
        xact(0, 1'b1, 32'h1008, '0);
        xact(0, 1'b1, 32'h1080, '0, 0, 1'b1, 64'd3);
        xact(0, 1'b1, 32'h1088, '0, 0, 1'b1, 64'd3);
        xact(0, 1'b0, 32'h1088, 64'h7);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_hold_req();
        test_reset_mid();
        test_back_to_back();
`ifdef TL_SYS_TGT_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
